// File: rtl/uc_pkg.sv
// Shared definitions for the microc control unit: FSM states, opcode
// constants, ALU operation codes and the decoded control word.
package uc_pkg;

    typedef enum logic [1:0] {
        INIT      = 2'd0,
        EXEC      = 2'd1,
        SKIP_EVAL = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CLS_LI   = 3'd0,
        CLS_ALU  = 3'd1,
        CLS_NOP  = 3'd2,
        CLS_SKIP = 3'd3,
        CLS_JR   = 3'd4
    } opclass_t;

    localparam logic [5:0] OP_SKIPNE = 6'b111100;
    localparam logic [5:0] OP_SKIPEQ = 6'b111101;
    localparam logic [5:0] OP_SKIPC  = 6'b111110;
    localparam logic [5:0] OP_JR     = 6'b111111;

    localparam logic [2:0] ALUOP_NONE = 3'b000;
    localparam logic [2:0] ADD        = 3'b010;
    localparam logic [2:0] SUB        = 3'b011;

    // Skip condition codes, taken from Opcode[1:0] of the SKIPxx instructions
    localparam logic [1:0] COND_NE = 2'b00;
    localparam logic [1:0] COND_EQ = 2'b01;
    localparam logic [1:0] COND_C  = 2'b10;

    // Control word produced by the decoder for the EXEC state
    typedef struct packed {
        logic       we;
        logic       s_inm;
        logic       s_inc;
        logic       pc_en;
        logic [2:0] aluop;
        logic       is_skip;
        logic       upd_flags;
    } ctrl_t;

    // Map a raw opcode onto its instruction class; anything unlisted is a NOP
    function automatic opclass_t classify(input logic [5:0] op);
        opclass_t cls;
        casez (op)
            6'b00????: cls = CLS_LI;
            6'b01????: cls = CLS_ALU;
            6'b10????: cls = CLS_NOP;
            OP_SKIPNE,
            OP_SKIPEQ,
            OP_SKIPC:  cls = CLS_SKIP;
            OP_JR:     cls = CLS_JR;
            default:   cls = CLS_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/uc_decode.sv
// Combinational opcode decoder: turns an opcode class into the control word
// the FSM drives while in EXEC.
module uc_decode
    import uc_pkg::*;
#(
    parameter logic [2:0] CMP_ALUOP = SUB
) (
    input  logic [5:0] opcode_i,
    output ctrl_t      ctrl_o
);

    // Start from a NOP control word, then override per instruction class
    always_comb begin
        ctrl_o.we        = 1'b0;
        ctrl_o.s_inm     = 1'b0;
        ctrl_o.s_inc     = 1'b1;
        ctrl_o.pc_en     = 1'b1;
        ctrl_o.aluop     = ALUOP_NONE;
        ctrl_o.is_skip   = 1'b0;
        ctrl_o.upd_flags = 1'b0;
        case (classify(opcode_i))
            CLS_LI: begin
                ctrl_o.we    = 1'b1;
                ctrl_o.s_inm = 1'b1;
            end
            CLS_ALU: begin
                ctrl_o.we        = 1'b1;
                ctrl_o.aluop     = opcode_i[2:0];
                ctrl_o.upd_flags = 1'b1;
            end
            CLS_SKIP: begin
                ctrl_o.aluop     = CMP_ALUOP;
                ctrl_o.pc_en     = 1'b0;
                ctrl_o.is_skip   = 1'b1;
                ctrl_o.upd_flags = 1'b1;
            end
            CLS_JR: begin
                ctrl_o.s_inc = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/uc_microc.sv
// Control unit for the microc datapath: sequences INIT/EXEC/SKIP_EVAL,
// holds the registered flags and counts retired instructions.
module uc_microc
    import uc_pkg::*;
#(
    parameter int         RETIRED_W = 16,
    parameter logic [2:0] CMP_ALUOP = 3'b011
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           Opcode,
    input  logic                 zero,
    input  logic                 carry,
    output logic                 s_skip,
    output logic                 s_inc,
    output logic                 s_inm,
    output logic                 we,
    output logic [2:0]           ALUOp,
    output logic                 pc_en,
    output logic                 flag_z,
    output logic                 flag_c,
    output logic [RETIRED_W-1:0] retired
);

    state_t               state_q, state_d;
    logic [1:0]           cond_q, cond_d;
    logic                 flag_z_q, flag_z_d;
    logic                 flag_c_q, flag_c_d;
    logic [RETIRED_W-1:0] retired_q, retired_d;
    ctrl_t                ctrl;

    uc_decode #(
        .CMP_ALUOP (CMP_ALUOP)
    ) u_decode (
        .opcode_i (Opcode),
        .ctrl_o   (ctrl)
    );

    // Next-state, outputs and register next-values; INIT outputs are the defaults
    always_comb begin
        state_d   = state_q;
        cond_d    = cond_q;
        flag_z_d  = flag_z_q;
        flag_c_d  = flag_c_q;
        we        = 1'b0;
        pc_en     = 1'b0;
        s_skip    = 1'b0;
        s_inc     = 1'b1;
        s_inm     = 1'b0;
        ALUOp     = ALUOP_NONE;
        case (state_q)
            INIT: begin
                state_d = EXEC;
            end
            EXEC: begin
                we    = ctrl.we;
                pc_en = ctrl.pc_en;
                s_inc = ctrl.s_inc;
                s_inm = ctrl.s_inm;
                ALUOp = ctrl.aluop;
                if (ctrl.upd_flags) begin
                    flag_z_d = zero;
                    flag_c_d = carry;
                end
                if (ctrl.is_skip) begin
                    cond_d  = Opcode[1:0];
                    state_d = SKIP_EVAL;
                end
            end
            SKIP_EVAL: begin
                pc_en = 1'b1;
                ALUOp = CMP_ALUOP;
                case (cond_q)
                    COND_NE: s_skip = ~flag_z_q;
                    COND_EQ: s_skip = flag_z_q;
                    COND_C:  s_skip = flag_c_q;
                    default: s_skip = 1'b0;
                endcase
                state_d = EXEC;
            end
            default: begin
                state_d = INIT;
            end
        endcase
        retired_d = pc_en ? retired_q + RETIRED_W'(1) : retired_q;
    end

    // State, flags, skip condition and retired counter with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INIT;
            cond_q    <= COND_NE;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cond_q    <= cond_d;
            flag_z_q  <= flag_z_d;
            flag_c_q  <= flag_c_d;
            retired_q <= retired_d;
        end
    end

    assign flag_z  = flag_z_q;
    assign flag_c  = flag_c_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_uc_microc.sv
// Directed testbench for uc_microc: walks through reset, LI, skips, ALU,
// JR with counter wrap and a reset in the middle of a skip.
module tb_uc_microc;

    localparam logic [5:0] OPC_LI     = 6'b000000;
    localparam logic [5:0] OPC_ADD    = 6'b010010;
    localparam logic [5:0] OPC_NOP    = 6'b100000;
    localparam logic [5:0] OPC_SKIPNE = 6'b111100;
    localparam logic [5:0] OPC_SKIPEQ = 6'b111101;
    localparam logic [5:0] OPC_SKIPC  = 6'b111110;
    localparam logic [5:0] OPC_JR     = 6'b111111;

    logic        clk;
    logic        reset;
    logic [5:0]  Opcode;
    logic        zero;
    logic        carry;
    logic        s_skip;
    logic        s_inc;
    logic        s_inm;
    logic        we;
    logic [2:0]  ALUOp;
    logic        pc_en;
    logic        flag_z;
    logic        flag_c;
    logic [15:0] retired;

    int total;
    int bad;

    uc_microc #(
        .RETIRED_W (16),
        .CMP_ALUOP (3'b011)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .Opcode  (Opcode),
        .zero    (zero),
        .carry   (carry),
        .s_skip  (s_skip),
        .s_inc   (s_inc),
        .s_inm   (s_inm),
        .we      (we),
        .ALUOp   (ALUOp),
        .pc_en   (pc_en),
        .flag_z  (flag_z),
        .flag_c  (flag_c),
        .retired (retired)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Wait for the next rising edge, then drive new inputs and let them settle
    task automatic applyStimulus(input logic [5:0] op, input logic z,
                                 input logic c, input logic rst);
        @(posedge clk);
        #1;
        Opcode = op;
        zero   = z;
        carry  = c;
        reset  = rst;
        #1;
    endtask

    // Compare one observed value with its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Linear directed sequence
    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        Opcode = OPC_LI;
        zero   = 1'b0;
        carry  = 1'b0;

        $display("[TB] reset phase");
        applyStimulus(OPC_LI, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_we", 32'(we), 32'd0);
        checkOutput("rst_pc_en", 32'(pc_en), 32'd0);
        checkOutput("rst_retired", 32'(retired), 32'd0);
        checkOutput("rst_flag_z", 32'(flag_z), 32'd0);

        // Release reset: this cycle is INIT
        applyStimulus(OPC_LI, 1'b0, 1'b0, 1'b0);
        checkOutput("init_we", 32'(we), 32'd0);
        checkOutput("init_pc_en", 32'(pc_en), 32'd0);
        checkOutput("init_s_inc", 32'(s_inc), 32'd1);
        checkOutput("init_retired", 32'(retired), 32'd0);

        $display("[TB] LI decode");
        applyStimulus(OPC_LI, 1'b0, 1'b0, 1'b0);
        checkOutput("li_we", 32'(we), 32'd1);
        checkOutput("li_s_inm", 32'(s_inm), 32'd1);
        checkOutput("li_s_inc", 32'(s_inc), 32'd1);
        checkOutput("li_s_skip", 32'(s_skip), 32'd0);
        checkOutput("li_pc_en", 32'(pc_en), 32'd1);
        checkOutput("li_retired_before", 32'(retired), 32'd0);

        $display("[TB] SKIPNE taken");
        applyStimulus(OPC_SKIPNE, 1'b0, 1'b0, 1'b0);
        checkOutput("li_retired_after", 32'(retired), 32'd1);
        checkOutput("sne1_aluop", 32'(ALUOp), 32'd3);
        checkOutput("sne1_pc_en", 32'(pc_en), 32'd0);
        checkOutput("sne1_we", 32'(we), 32'd0);
        applyStimulus(OPC_SKIPNE, 1'b1, 1'b1, 1'b0);
        checkOutput("sne2_s_skip", 32'(s_skip), 32'd1);
        checkOutput("sne2_pc_en", 32'(pc_en), 32'd1);
        checkOutput("sne2_flag_z", 32'(flag_z), 32'd0);
        checkOutput("sne2_aluop", 32'(ALUOp), 32'd3);
        checkOutput("sne2_retired", 32'(retired), 32'd1);

        $display("[TB] SKIPNE not taken");
        applyStimulus(OPC_SKIPNE, 1'b1, 1'b0, 1'b0);
        checkOutput("snn1_pc_en", 32'(pc_en), 32'd0);
        checkOutput("snn1_retired", 32'(retired), 32'd2);
        applyStimulus(OPC_SKIPNE, 1'b0, 1'b0, 1'b0);
        checkOutput("snn2_s_skip", 32'(s_skip), 32'd0);
        checkOutput("snn2_flag_z", 32'(flag_z), 32'd1);

        $display("[TB] ADD after skip");
        applyStimulus(OPC_ADD, 1'b0, 1'b1, 1'b0);
        checkOutput("add_aluop", 32'(ALUOp), 32'd2);
        checkOutput("add_we", 32'(we), 32'd1);
        checkOutput("add_s_inm", 32'(s_inm), 32'd0);
        checkOutput("add_pc_en", 32'(pc_en), 32'd1);
        checkOutput("add_retired", 32'(retired), 32'd3);

        $display("[TB] SKIPC taken");
        applyStimulus(OPC_SKIPC, 1'b1, 1'b1, 1'b0);
        checkOutput("add_flag_z", 32'(flag_z), 32'd0);
        checkOutput("add_flag_c", 32'(flag_c), 32'd1);
        checkOutput("sc1_pc_en", 32'(pc_en), 32'd0);
        applyStimulus(OPC_SKIPC, 1'b0, 1'b0, 1'b0);
        checkOutput("sc2_s_skip", 32'(s_skip), 32'd1);
        checkOutput("sc2_flag_c", 32'(flag_c), 32'd1);
        checkOutput("sc2_flag_z", 32'(flag_z), 32'd1);

        $display("[TB] SKIPEQ not taken");
        applyStimulus(OPC_SKIPEQ, 1'b0, 1'b0, 1'b0);
        checkOutput("seq1_retired", 32'(retired), 32'd5);
        applyStimulus(OPC_SKIPEQ, 1'b1, 1'b1, 1'b0);
        checkOutput("seq2_s_skip", 32'(s_skip), 32'd0);
        checkOutput("seq2_flag_z", 32'(flag_z), 32'd0);

        $display("[TB] JR and counter wrap");
        applyStimulus(OPC_JR, 1'b0, 1'b0, 1'b0);
        checkOutput("jr_s_inc", 32'(s_inc), 32'd0);
        checkOutput("jr_we", 32'(we), 32'd0);
        checkOutput("jr_pc_en", 32'(pc_en), 32'd1);
        checkOutput("jr_retired", 32'(retired), 32'd6);
        applyStimulus(OPC_NOP, 1'b0, 1'b0, 1'b0);
        checkOutput("nop_we", 32'(we), 32'd0);
        checkOutput("nop_pc_en", 32'(pc_en), 32'd1);
        checkOutput("nop_retired", 32'(retired), 32'd7);
        for (int i = 0; i < 65527; i++) begin
            applyStimulus(OPC_NOP, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("pre_wrap_retired", 32'(retired), 32'h0000_FFFE);
        applyStimulus(OPC_JR, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_jr_retired", 32'(retired), 32'h0000_FFFF);
        checkOutput("wrap_jr_s_inc", 32'(s_inc), 32'd0);
        applyStimulus(OPC_NOP, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_retired", 32'(retired), 32'd0);

        $display("[TB] reset during SKIP_EVAL");
        applyStimulus(OPC_SKIPC, 1'b1, 1'b1, 1'b0);
        checkOutput("ms1_pc_en", 32'(pc_en), 32'd0);
        applyStimulus(OPC_SKIPC, 1'b0, 1'b0, 1'b1);
        checkOutput("ms2_s_skip", 32'(s_skip), 32'd1);
        checkOutput("ms2_flag_z", 32'(flag_z), 32'd1);
        checkOutput("ms2_retired", 32'(retired), 32'd1);
        applyStimulus(OPC_LI, 1'b0, 1'b0, 1'b0);
        checkOutput("ms3_s_skip", 32'(s_skip), 32'd0);
        checkOutput("ms3_flag_z", 32'(flag_z), 32'd0);
        checkOutput("ms3_flag_c", 32'(flag_c), 32'd0);
        checkOutput("ms3_retired", 32'(retired), 32'd0);
        checkOutput("ms3_pc_en", 32'(pc_en), 32'd0);
        applyStimulus(OPC_LI, 1'b0, 1'b0, 1'b0);
        checkOutput("ms4_we", 32'(we), 32'd1);
        checkOutput("ms4_pc_en", 32'(pc_en), 32'd1);
        applyStimulus(OPC_NOP, 1'b0, 1'b0, 1'b0);
        checkOutput("ms5_retired", 32'(retired), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uc_microc.md
Name: uc_microc

Overview:
- Control unit that sits directly upstream of the microc datapath and drives its control inputs.
- Decodes the 6-bit Opcode (instr[15:10]) returned by the datapath, together with the zero and carry flags.
- Generates s_skip, s_inc, s_inm, we and ALUOp, so directed benches no longer hand-drive them.
- Adds a PC-enable, registered flags and a retired-instruction counter. Conditional skips are two-cycle operations.

Parameters:
- RETIRED_W, 16, width of the retired-instruction counter.
- CMP_ALUOP, 3'b011, ALUOp issued for skip compares (A - B).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Opcode  in  6  instr[15:10] from the datapath.
- zero  in  1  ALU zero flag from the datapath (combinational, current cycle).
- carry  in  1  ALU carry flag from the datapath.
- s_skip  out  1  1: PC increment is 2; 0: increment is 1.
- s_inc  out  1  1: PC + increment; 0: PC + jump offset.
- s_inm  out  1  1: register-file write data is the immediate; 0: ALU result.
- we  out  1  register-file write enable.
- ALUOp  out  3  ALU operation select.
- pc_en  out  1  PC load enable. The datapath holds PC when 0.
- flag_z  out  1  registered zero flag.
- flag_c  out  1  registered carry flag.
- retired  out  RETIRED_W  count of completed instructions.

Behaviour:
- Opcode classes:
  - 00xxxx: LI.
  - 01xxxx: ALU register-register; ALUOp = Opcode[2:0].
  - 10xxxx: reserved, executes as NOP.
  - 111100: SKIPNE.
  - 111101: SKIPEQ.
  - 111110: SKIPC.
  - 111111: JR.
- States are INIT, EXEC and SKIP_EVAL.
- Reset (synchronous, any state, including mid-skip):
  - next state INIT; flag_z = flag_c = 0; retired = 0.
- INIT, for one cycle after reset deasserts:
  - we = 0, pc_en = 0, s_skip = 0, s_inc = 1, s_inm = 0, ALUOp = 000.
  - Next state EXEC.
- EXEC outputs are combinational from Opcode.
  - LI: we = 1, s_inm = 1, s_inc = 1, s_skip = 0, pc_en = 1, ALUOp = 000.
  - ALU: we = 1, s_inm = 0, s_inc = 1, s_skip = 0, pc_en = 1. flag_z and flag_c capture zero and carry at the edge.
  - NOP: we = 0, s_inc = 1, s_skip = 0, pc_en = 1.
  - JR: we = 0, s_inc = 0, s_skip = 0, pc_en = 1.
  - SKIPxx:
    - Outputs: ALUOp = CMP_ALUOP, we = 0, pc_en = 0 (PC held, so Opcode stays stable).
    - At the edge: flags capture zero/carry, Opcode[1:0] latches into cond_q, next state SKIP_EVAL.
- SKIP_EVAL, one cycle:
  - we = 0, s_inc = 1, pc_en = 1, ALUOp = CMP_ALUOP.
  - s_skip from cond_q: 00 → !flag_z; 01 → flag_z; 10 → flag_c.
  - Flags are not updated in this cycle. Next state EXEC.
- retired increments on every edge with pc_en = 1. It wraps from all-ones to 0 with no saturation.
- Latency: 1 cycle per instruction; SKIPxx takes 2.
- There is no hazard between consecutive SKIPs, since each re-captures flags in its own EXEC cycle.
- Unknown or X Opcode in EXEC is decoded as NOP.

Decomposition:
- Package uc_pkg holds:
  - state encoding (INIT = 2'd0, EXEC = 2'd1, SKIP_EVAL = 2'd2);
  - opcode class constants (OP_SKIPNE = 6'b111100, etc.);
  - ALUOp constants (ADD = 3'b010, SUB = 3'b011).
- One natural sub-module, uc_decode: purely combinational mapping of opcode class to control word. The FSM, flags and counter stay in uc_microc.

Test Plan:
- Reset check: reset high for 2 cycles, then low.
  - During reset and in the INIT cycle: we = 0, pc_en = 0, retired = 0.
  - First EXEC on the following cycle.
- LI decode: Opcode = 000000.
  - we = 1, s_inm = 1, s_inc = 1, s_skip = 0, pc_en = 1; retired goes 0 → 1.
- SKIPNE taken: Opcode = 111100 with zero = 0 in EXEC.
  - Cycle 1: ALUOp = 011, pc_en = 0, we = 0.
  - Cycle 2: s_skip = 1, pc_en = 1; flag_z = 0.
- SKIPNE not taken: same as above but zero = 1.
  - Cycle 2: s_skip = 0; flag_z = 1.
  - The ADD that follows (Opcode = 010010): ALUOp = 010, we = 1, s_inm = 0.
- JR and counter wrap: Opcode = 111111.
  - s_inc = 0, we = 0, pc_en = 1.
  - Preload the count to FFFF via 65535 NOPs (Opcode = 100000); the next JR makes retired = 0000.
- Reset mid-skip: assert reset during SKIP_EVAL.
  - Next cycle is INIT, s_skip = 0, flags = 0, retired = 0.
